fb_port_arbiter: RTL and testbench
==================================

# fb_port_arbiter

Arbiter and sequencer for the single framebuffer SRAM port shared by the rasterizer pixel-write stream, the display scanout reader and a built-in frame-clear engine. It replaces the per-pixel clear loop in the rasterizer with a dedicated clear sequencer, and asserts a frame stall while a clear runs. Memory commands leave the block registered, one command per cycle.

## Interface
- FB_WIDTH, 640, pixels per row
- FB_HEIGHT, 400, rows; FB_SIZE = FB_WIDTH*FB_HEIGHT (256000)
- ADDR_W, 18, memory address width
- DATA_W, 64, pixel/word width
- CLEAR_VALUE, 0, word written by clear engine
- STARVE_LIMIT, 8, consecutive denied cycles before raster beats scanout
- I_CLOCK  in  1  clock; all state changes on rising edge
- I_RESET_N  in  1  asynchronous, active-low reset
- I_CLEAR_REQ  in  1  one-cycle start-clear pulse
- O_CLEAR_BUSY  out  1  clear in progress
- O_CLEAR_DONE  out  1  one-cycle pulse after last clear write issued
- O_FRAMESTALL  out  1  equals O_CLEAR_BUSY
- I_RS_VALID, I_RS_ADDR[ADDR_W], I_RS_DATA[DATA_W]  in  raster write request
- O_RS_READY  out  1  raster write accepted this cycle
- I_SO_REQ, I_SO_ADDR[ADDR_W]  in  scanout read request
- O_SO_GNT  out  1  scanout read accepted this cycle
- O_SO_RVALID  out  1, O_SO_RDATA  out  DATA_W  read return
- O_MEM_ADDR[ADDR_W], O_MEM_WDATA[DATA_W], O_MEM_WE, O_MEM_RE  out  registered memory command
- I_MEM_RDATA  in  DATA_W  valid in the cycle after O_MEM_RE
- O_DROP_CNT  out  16  saturating count of dropped raster writes

## Operation
- States: IDLE, CLEAR. Reset -> IDLE.
- IDLE -> CLEAR on I_CLEAR_REQ; clear counter loads 0. I_CLEAR_REQ while in CLEAR ignored (no restart).
- CLEAR: each cycle the clear engine is granted, it issues write addr=counter, data=CLEAR_VALUE, counter++. After issuing addr FB_SIZE-1: -> IDLE, O_CLEAR_DONE pulses one cycle, O_CLEAR_BUSY low from that edge.
- Per-cycle grant (combinational from current inputs/state), priority: raster-starved raster > scanout > clear > raster. Exactly one grant or none per cycle.
- O_RS_READY forced 0 in CLEAR (raster held off for whole clear, including the cycle I_CLEAR_REQ is sampled if arbitration picks clear state; in IDLE on the request cycle raster may still win).
- Raster transfer = I_RS_VALID & O_RS_READY at edge. If I_RS_ADDR >= FB_SIZE: transfer completes, no memory write, O_DROP_CNT++ (saturates at 16'hFFFF).
- Starvation counter: increments each cycle I_RS_VALID=1 and O_RS_READY=0 in IDLE; clears on raster transfer, on I_RS_VALID=0 and in CLEAR. At STARVE_LIMIT raster wins over scanout.
- Scanout transfer = I_SO_REQ & O_SO_GNT; address not range-checked.
- Idle cycle (no grant): O_MEM_WE=O_MEM_RE=0, address/data hold.

## Timing
- Grant at edge E0 -> O_MEM_* show that command during cycle E0..E1 (1-cycle command latency).
- Read: O_SO_RVALID high for exactly one cycle starting at E1; O_SO_RDATA = I_MEM_RDATA in that cycle. Back-to-back grants give back-to-back returns.
- Full clear with no scanout contention: O_CLEAR_BUSY high exactly FB_SIZE cycles; each scanout grant during CLEAR adds one cycle.
- Reset (asynchronous, any time including mid-clear): state IDLE, all outputs 0, O_MEM_WE/O_MEM_RE deassert immediately, clear counter, starvation counter and O_DROP_CNT 0; a pending read return is discarded. Clear does not resume after reset.
- O_CLEAR_DONE and O_CLEAR_BUSY never high together.

## Test plan
- FB_WIDTH=8, FB_HEIGHT=4, no other traffic, I_CLEAR_REQ pulse -> 32 consecutive writes addr 0..31 data 0, O_CLEAR_BUSY high 32 cycles, O_CLEAR_DONE one pulse on cycle 33.
- Same config, I_SO_REQ held high during clear, STARVE_LIMIT=8 -> all writes still issued addr 0..31, clear stalled entirely until I_SO_REQ drops; RVALID one cycle after each grant with model data.
- Raster I_RS_VALID held with I_SO_REQ always high, STARVE_LIMIT=8 -> O_RS_READY high on 9th cycle, then scanout resumes; repeats every 9 cycles.
- Raster writes to addr 31 then 32 (FB_SIZE=32) -> one memory write addr 31; O_DROP_CNT=1; both handshakes complete.
- I_CLEAR_REQ and I_RS_VALID in same IDLE cycle -> raster write issued that cycle (single grant), clear starts next cycle, O_RS_READY 0 until O_CLEAR_DONE.
- I_RESET_N low at clear address 10 -> O_MEM_WE 0 immediately, O_CLEAR_BUSY 0, no further writes after release; new I_CLEAR_REQ restarts at addr 0.

Source files
------------

// File: rtl/fb_port_arbiter.sv
// Single-port framebuffer arbiter: raster writes, scanout reads and a built-in
// frame-clear sequencer share one registered memory command per cycle.
module fb_port_arbiter #(
    parameter int                FB_WIDTH     = 640,
    parameter int                FB_HEIGHT    = 400,
    parameter int                ADDR_W       = 18,
    parameter int                DATA_W       = 64,
    parameter logic [DATA_W-1:0] CLEAR_VALUE  = '0,
    parameter int                STARVE_LIMIT = 8
) (
    input  logic              I_CLOCK,
    input  logic              I_RESET_N,
    input  logic              I_CLEAR_REQ,
    output logic              O_CLEAR_BUSY,
    output logic              O_CLEAR_DONE,
    output logic              O_FRAMESTALL,
    input  logic              I_RS_VALID,
    input  logic [ADDR_W-1:0] I_RS_ADDR,
    input  logic [DATA_W-1:0] I_RS_DATA,
    output logic              O_RS_READY,
    input  logic              I_SO_REQ,
    input  logic [ADDR_W-1:0] I_SO_ADDR,
    output logic              O_SO_GNT,
    output logic              O_SO_RVALID,
    output logic [DATA_W-1:0] O_SO_RDATA,
    output logic [ADDR_W-1:0] O_MEM_ADDR,
    output logic [DATA_W-1:0] O_MEM_WDATA,
    output logic              O_MEM_WE,
    output logic              O_MEM_RE,
    input  logic [DATA_W-1:0] I_MEM_RDATA,
    output logic [15:0]       O_DROP_CNT
);

    localparam int                FB_SIZE     = FB_WIDTH * FB_HEIGHT;
    localparam logic [ADDR_W:0]   FB_SIZE_EXT = (ADDR_W+1)'(FB_SIZE);
    localparam logic [ADDR_W-1:0] LAST_ADDR   = ADDR_W'(FB_SIZE - 1);
    localparam int                STARVE_W    = (STARVE_LIMIT < 1) ? 1 : $clog2(STARVE_LIMIT + 1);
    localparam logic [STARVE_W-1:0] STARVE_MAX = STARVE_W'(STARVE_LIMIT);

    typedef enum logic {IDLE, CLEAR} state_t;

    state_t              state_q, state_d;
    logic [ADDR_W-1:0]   clr_cnt_q, clr_cnt_d;
    logic [STARVE_W-1:0] starve_q, starve_d;
    logic [15:0]         drop_q, drop_d;
    logic                done_q, done_d;
    logic                rvalid_q, rvalid_d;
    logic                mem_we_q, mem_we_d;
    logic                mem_re_q, mem_re_d;
    logic [ADDR_W-1:0]   mem_addr_q, mem_addr_d;
    logic [DATA_W-1:0]   mem_wdata_q, mem_wdata_d;

    logic in_clear, starved, gnt_rs, gnt_so, gnt_clr, rs_in_range;

    // Priority: starved raster > scanout > clear > raster; raster is locked out during a clear.
    always_comb begin
        in_clear    = (state_q == CLEAR);
        starved     = (starve_q >= STARVE_MAX);
        gnt_rs      = !in_clear && I_RS_VALID && (starved || !I_SO_REQ);
        gnt_so      = I_SO_REQ && !gnt_rs;
        gnt_clr     = in_clear && !I_SO_REQ;
        rs_in_range = ({1'b0, I_RS_ADDR} < FB_SIZE_EXT);
    end

    always_comb begin
        state_d     = state_q;
        clr_cnt_d   = clr_cnt_q;
        drop_d      = drop_q;
        done_d      = 1'b0;
        rvalid_d    = mem_re_q;
        mem_we_d    = 1'b0;
        mem_re_d    = 1'b0;
        mem_addr_d  = mem_addr_q;
        mem_wdata_d = mem_wdata_q;
        starve_d    = starve_q;

        if (!in_clear && I_CLEAR_REQ) begin
            state_d   = CLEAR;
            clr_cnt_d = '0;
        end

        if (gnt_clr) begin
            mem_we_d    = 1'b1;
            mem_addr_d  = clr_cnt_q;
            mem_wdata_d = CLEAR_VALUE;
            clr_cnt_d   = clr_cnt_q + ADDR_W'(1);
            if (clr_cnt_q == LAST_ADDR) begin
                state_d = IDLE;
                done_d  = 1'b1;
            end
        end

        if (gnt_so) begin
            mem_re_d   = 1'b1;
            mem_addr_d = I_SO_ADDR;
        end

        // Out-of-range raster writes still handshake but never reach memory.
        if (gnt_rs) begin
            if (rs_in_range) begin
                mem_we_d    = 1'b1;
                mem_addr_d  = I_RS_ADDR;
                mem_wdata_d = I_RS_DATA;
            end else if (drop_q != 16'hFFFF) begin
                drop_d = drop_q + 16'd1;
            end
        end

        if (in_clear || !I_RS_VALID || gnt_rs) begin
            starve_d = '0;
        end else if (!starved) begin
            starve_d = starve_q + STARVE_W'(1);
        end
    end

    always_ff @(posedge I_CLOCK or negedge I_RESET_N) begin
        if (!I_RESET_N) begin
            state_q     <= IDLE;
            clr_cnt_q   <= '0;
            starve_q    <= '0;
            drop_q      <= '0;
            done_q      <= 1'b0;
            rvalid_q    <= 1'b0;
            mem_we_q    <= 1'b0;
            mem_re_q    <= 1'b0;
            mem_addr_q  <= '0;
            mem_wdata_q <= '0;
        end else begin
            state_q     <= state_d;
            clr_cnt_q   <= clr_cnt_d;
            starve_q    <= starve_d;
            drop_q      <= drop_d;
            done_q      <= done_d;
            rvalid_q    <= rvalid_d;
            mem_we_q    <= mem_we_d;
            mem_re_q    <= mem_re_d;
            mem_addr_q  <= mem_addr_d;
            mem_wdata_q <= mem_wdata_d;
        end
    end

    assign O_CLEAR_BUSY = in_clear;
    assign O_FRAMESTALL = in_clear;
    assign O_CLEAR_DONE = done_q;
    assign O_RS_READY   = gnt_rs;
    assign O_SO_GNT     = gnt_so;
    assign O_SO_RVALID  = rvalid_q;
    assign O_SO_RDATA   = rvalid_q ? I_MEM_RDATA : '0;
    assign O_MEM_ADDR   = mem_addr_q;
    assign O_MEM_WDATA  = mem_wdata_q;
    assign O_MEM_WE     = mem_we_q;
    assign O_MEM_RE     = mem_re_q;
    assign O_DROP_CNT   = drop_q;

endmodule

// File: tb/tb_fb_port_arbiter.sv
// Directed bench for fb_port_arbiter on a 8x4 framebuffer: vector table for
// single-cycle arbitration plus hand sequences for starvation, clear and reset.
module tb_fb_port_arbiter;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        clear_req = 1'b0;
    logic        rs_valid = 1'b0;
    logic [17:0] rs_addr = '0;
    logic [63:0] rs_data = '0;
    logic        so_req = 1'b0;
    logic [17:0] so_addr = '0;
    logic [63:0] mem_rdata = '0;
    logic        clear_busy, clear_done, framestall, rs_ready, so_gnt, so_rvalid;
    logic [63:0] so_rdata, mem_wdata;
    logic [17:0] mem_addr;
    logic        mem_we, mem_re;
    logic [15:0] drop_cnt;

    int passed = 0;
    int total = 0;

    fb_port_arbiter #(.FB_WIDTH(8), .FB_HEIGHT(4), .ADDR_W(18), .DATA_W(64),
                      .CLEAR_VALUE(64'd0), .STARVE_LIMIT(8)) dut (
        .I_CLOCK(clk), .I_RESET_N(rst_n), .I_CLEAR_REQ(clear_req),
        .O_CLEAR_BUSY(clear_busy), .O_CLEAR_DONE(clear_done), .O_FRAMESTALL(framestall),
        .I_RS_VALID(rs_valid), .I_RS_ADDR(rs_addr), .I_RS_DATA(rs_data), .O_RS_READY(rs_ready),
        .I_SO_REQ(so_req), .I_SO_ADDR(so_addr), .O_SO_GNT(so_gnt),
        .O_SO_RVALID(so_rvalid), .O_SO_RDATA(so_rdata),
        .O_MEM_ADDR(mem_addr), .O_MEM_WDATA(mem_wdata), .O_MEM_WE(mem_we), .O_MEM_RE(mem_re),
        .I_MEM_RDATA(mem_rdata), .O_DROP_CNT(drop_cnt)
    );

    always #5 clk = ~clk;

    function automatic logic [63:0] pat(input logic [17:0] a);
        return {32'hA5A5_5A5A, 14'h0, a};
    endfunction

    // Memory model: read data appears the cycle after the registered read command.
    always @(posedge clk) mem_rdata <= mem_re ? pat(mem_addr) : 64'd0;

    logic        mon_en = 1'b0;
    int          busy_cycles = 0;
    int          done_pulses = 0;
    int          overlap = 0;
    logic [17:0] wr_addr_q[$];
    logic [63:0] wr_data_q[$];
    logic [63:0] rv_q[$];

    always @(negedge clk) begin
        if (clear_busy && clear_done) overlap++;
        if (mon_en) begin
            if (clear_busy) busy_cycles++;
            if (clear_done) done_pulses++;
            if (mem_we) begin
                wr_addr_q.push_back(mem_addr);
                wr_data_q.push_back(mem_wdata);
            end
            if (so_rvalid) rv_q.push_back(so_rdata);
        end
    end

    task automatic checkOutput(input string name, input logic [63:0] act, input logic [63:0] exp);
        total++;
        if (act === exp) passed++;
        else $display("[TB] FAIL %s: got %0h expected %0h", name, act, exp);
    endtask

    task automatic applyStimulus(input logic crq, input logic rv, input logic [17:0] ra,
                                 input logic [63:0] rd, input logic sr, input logic [17:0] sa);
        clear_req = crq;
        rs_valid  = rv;
        rs_addr   = ra;
        rs_data   = rd;
        so_req    = sr;
        so_addr   = sa;
    endtask

    task automatic startMonitor();
        busy_cycles = 0;
        done_pulses = 0;
        wr_addr_q.delete();
        wr_data_q.delete();
        rv_q.delete();
        mon_en = 1'b1;
    endtask

    task automatic waitDone(input int limit);
        int n = 0;
        while (!clear_done && n < limit) begin
            @(posedge clk); #1;
            n++;
        end
        checkOutput("done_seen", clear_done, 1'b1);
    endtask

    task automatic checkClearWrites(input string tag);
        checkOutput({tag, "_wr_cnt"}, wr_addr_q.size(), 32);
        for (int i = 0; i < wr_addr_q.size() && i < 32; i++) begin
            checkOutput($sformatf("%s_wr%0d_addr", tag, i), wr_addr_q[i], i);
            checkOutput($sformatf("%s_wr%0d_data", tag, i), wr_data_q[i], 64'd0);
        end
    endtask

    typedef struct {
        logic        rsv;
        logic [17:0] rsa;
        logic [63:0] rsd;
        logic        sor;
        logic [17:0] soa;
        logic        rdy;
        logic        gnt;
        logic        we;
        logic        re;
        logic [17:0] addr;
        logic [63:0] wdata;
        logic        rv;
        logic [63:0] rdata;
        logic [15:0] drop;
    } vec_t;

    vec_t vecs[12];

    initial begin
        int n;
        logic saw_rdy;

        vecs[0]  = '{1'b1, 18'd5,       64'h1111, 1'b0, 18'd0,       1'b1, 1'b0, 1'b1, 1'b0, 18'd5,       64'h1111, 1'b0, 64'd0,            16'd0};
        vecs[1]  = '{1'b0, 18'd0,       64'h0,    1'b1, 18'd7,       1'b0, 1'b1, 1'b0, 1'b1, 18'd7,       64'h1111, 1'b0, 64'd0,            16'd0};
        vecs[2]  = '{1'b0, 18'd0,       64'h0,    1'b0, 18'd0,       1'b0, 1'b0, 1'b0, 1'b0, 18'd7,       64'h1111, 1'b1, pat(18'd7),       16'd0};
        vecs[3]  = '{1'b1, 18'd31,      64'h2222, 1'b1, 18'd9,       1'b0, 1'b1, 1'b0, 1'b1, 18'd9,       64'h1111, 1'b0, 64'd0,            16'd0};
        vecs[4]  = '{1'b1, 18'd31,      64'h2222, 1'b0, 18'd0,       1'b1, 1'b0, 1'b1, 1'b0, 18'd31,      64'h2222, 1'b1, pat(18'd9),       16'd0};
        vecs[5]  = '{1'b1, 18'd32,      64'h3333, 1'b0, 18'd0,       1'b1, 1'b0, 1'b0, 1'b0, 18'd31,      64'h2222, 1'b0, 64'd0,            16'd1};
        vecs[6]  = '{1'b1, 18'h3FFFF,   64'h4444, 1'b0, 18'd0,       1'b1, 1'b0, 1'b0, 1'b0, 18'd31,      64'h2222, 1'b0, 64'd0,            16'd2};
        vecs[7]  = '{1'b0, 18'd0,       64'h0,    1'b1, 18'h3FFFF,   1'b0, 1'b1, 1'b0, 1'b1, 18'h3FFFF,   64'h2222, 1'b0, 64'd0,            16'd2};
        vecs[8]  = '{1'b0, 18'd0,       64'h0,    1'b0, 18'd0,       1'b0, 1'b0, 1'b0, 1'b0, 18'h3FFFF,   64'h2222, 1'b1, pat(18'h3FFFF),   16'd2};
        vecs[9]  = '{1'b0, 18'd0,       64'h0,    1'b1, 18'd1,       1'b0, 1'b1, 1'b0, 1'b1, 18'd1,       64'h2222, 1'b0, 64'd0,            16'd2};
        vecs[10] = '{1'b0, 18'd0,       64'h0,    1'b1, 18'd2,       1'b0, 1'b1, 1'b0, 1'b1, 18'd2,       64'h2222, 1'b1, pat(18'd1),       16'd2};
        vecs[11] = '{1'b0, 18'd0,       64'h0,    1'b0, 18'd0,       1'b0, 1'b0, 1'b0, 1'b0, 18'd2,       64'h2222, 1'b1, pat(18'd2),       16'd2};

        // Reset state
        #2;
        checkOutput("rst_busy", clear_busy, 1'b0);
        checkOutput("rst_done", clear_done, 1'b0);
        checkOutput("rst_stall", framestall, 1'b0);
        checkOutput("rst_we", mem_we, 1'b0);
        checkOutput("rst_re", mem_re, 1'b0);
        checkOutput("rst_addr", mem_addr, 18'd0);
        checkOutput("rst_rvalid", so_rvalid, 1'b0);
        checkOutput("rst_drop", drop_cnt, 16'd0);
        repeat (3) @(negedge clk);
        rst_n = 1'b1;

        // Single-cycle arbitration vectors
        for (int i = 0; i < 12; i++) begin
            @(negedge clk);
            applyStimulus(1'b0, vecs[i].rsv, vecs[i].rsa, vecs[i].rsd, vecs[i].sor, vecs[i].soa);
            #1;
            checkOutput($sformatf("v%0d_rdy", i), rs_ready, vecs[i].rdy);
            checkOutput($sformatf("v%0d_gnt", i), so_gnt, vecs[i].gnt);
            @(posedge clk); #1;
            checkOutput($sformatf("v%0d_we", i), mem_we, vecs[i].we);
            checkOutput($sformatf("v%0d_re", i), mem_re, vecs[i].re);
            checkOutput($sformatf("v%0d_addr", i), mem_addr, vecs[i].addr);
            checkOutput($sformatf("v%0d_wdata", i), mem_wdata, vecs[i].wdata);
            checkOutput($sformatf("v%0d_rvalid", i), so_rvalid, vecs[i].rv);
            checkOutput($sformatf("v%0d_rdata", i), so_rdata, vecs[i].rdata);
            checkOutput($sformatf("v%0d_drop", i), drop_cnt, vecs[i].drop);
        end

        // Starvation: raster wins every 9th cycle against continuous scanout
        for (int c = 1; c <= 27; c++) begin
            @(negedge clk);
            applyStimulus(1'b0, 1'b1, 18'd3, 64'h55, 1'b1, 18'(20 + c));
            #1;
            checkOutput($sformatf("starve%0d_rdy", c), rs_ready, (c % 9) == 0);
            checkOutput($sformatf("starve%0d_gnt", c), so_gnt, (c % 9) != 0);
        end
        @(negedge clk);
        applyStimulus(1'b0, 1'b0, 18'd0, 64'd0, 1'b0, 18'd0);
        repeat (3) @(negedge clk);

        // Plain clear, no other traffic
        applyStimulus(1'b1, 1'b0, 18'd0, 64'd0, 1'b0, 18'd0);
        #1;
        startMonitor();
        checkOutput("clrA_req_rdy", rs_ready, 1'b0);
        checkOutput("clrA_req_gnt", so_gnt, 1'b0);
        @(posedge clk); #1;
        clear_req = 1'b0;
        checkOutput("clrA_busy", clear_busy, 1'b1);
        checkOutput("clrA_stall", framestall, 1'b1);
        checkOutput("clrA_first_we", mem_we, 1'b0);
        waitDone(100);
        checkOutput("clrA_busy_at_done", clear_busy, 1'b0);
        @(negedge clk); #1;
        mon_en = 1'b0;
        checkOutput("clrA_busy_cycles", busy_cycles, 32);
        checkOutput("clrA_done_pulses", done_pulses, 1);
        checkClearWrites("clrA");

        // Clear stalled by continuous scanout for 10 cycles
        @(negedge clk);
        applyStimulus(1'b1, 1'b0, 18'd0, 64'd0, 1'b1, 18'd100);
        #1;
        startMonitor();
        checkOutput("clrB_req_gnt", so_gnt, 1'b1);
        @(posedge clk); #1;
        checkOutput("clrB_busy", clear_busy, 1'b1);
        checkOutput("clrB_re", mem_re, 1'b1);
        for (int i = 1; i <= 10; i++) begin
            @(negedge clk);
            applyStimulus(1'b0, 1'b0, 18'd0, 64'd0, 1'b1, 18'(100 + i));
            #1;
            checkOutput($sformatf("clrB_gnt%0d", i), so_gnt, 1'b1);
            @(posedge clk); #1;
            checkOutput($sformatf("clrB_nowr%0d", i), mem_we, 1'b0);
        end
        @(negedge clk);
        so_req = 1'b0;
        waitDone(100);
        @(negedge clk); #1;
        mon_en = 1'b0;
        checkOutput("clrB_busy_cycles", busy_cycles, 42);
        checkOutput("clrB_done_pulses", done_pulses, 1);
        checkClearWrites("clrB");
        checkOutput("clrB_rv_cnt", rv_q.size(), 11);
        for (int i = 0; i < rv_q.size() && i < 11; i++)
            checkOutput($sformatf("clrB_rd%0d", i), rv_q[i], pat(18'(100 + i)));

        // Clear request and raster write in the same idle cycle
        @(negedge clk);
        applyStimulus(1'b1, 1'b1, 18'd4, 64'h4444, 1'b0, 18'd0);
        #1;
        checkOutput("clrC_req_rdy", rs_ready, 1'b1);
        @(posedge clk); #1;
        checkOutput("clrC_rs_we", mem_we, 1'b1);
        checkOutput("clrC_rs_addr", mem_addr, 18'd4);
        checkOutput("clrC_rs_wdata", mem_wdata, 64'h4444);
        checkOutput("clrC_busy", clear_busy, 1'b1);
        clear_req = 1'b0;
        @(negedge clk); #1;
        startMonitor();
        saw_rdy = 1'b0;
        n = 0;
        while (!clear_done && n < 100) begin
            if (rs_ready) saw_rdy = 1'b1;
            @(posedge clk); #1;
            n++;
            @(negedge clk); #1;
        end
        checkOutput("clrC_done_seen", clear_done, 1'b1);
        checkOutput("clrC_rdy_held_off", saw_rdy, 1'b0);
        mon_en = 1'b0;
        checkOutput("clrC_rdy_after", rs_ready, 1'b1);
        checkClearWrites("clrC");
        @(posedge clk); #1;
        checkOutput("clrC_late_we", mem_we, 1'b1);
        checkOutput("clrC_late_addr", mem_addr, 18'd4);
        @(negedge clk);
        applyStimulus(1'b0, 1'b0, 18'd0, 64'd0, 1'b0, 18'd0);

        // Reset in the middle of a clear
        @(negedge clk);
        clear_req = 1'b1;
        @(negedge clk);
        clear_req = 1'b0;
        n = 0;
        while (!(mem_we && mem_addr == 18'd10) && n < 100) begin
            @(negedge clk);
            n++;
        end
        checkOutput("rstmid_reached10", mem_addr, 18'd10);
        rst_n = 1'b0;
        #1;
        checkOutput("rstmid_we", mem_we, 1'b0);
        checkOutput("rstmid_busy", clear_busy, 1'b0);
        checkOutput("rstmid_addr", mem_addr, 18'd0);
        checkOutput("rstmid_drop", drop_cnt, 16'd0);
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        #1;
        startMonitor();
        repeat (5) @(negedge clk);
        #1;
        mon_en = 1'b0;
        checkOutput("rstmid_no_writes", wr_addr_q.size(), 0);
        checkOutput("rstmid_idle", busy_cycles, 0);
        clear_req = 1'b1;
        @(posedge clk); #1;
        clear_req = 1'b0;
        checkOutput("rstmid_restart_busy", clear_busy, 1'b1);
        @(posedge clk); #1;
        checkOutput("rstmid_restart_we", mem_we, 1'b1);
        checkOutput("rstmid_restart_addr", mem_addr, 18'd0);
        waitDone(100);
        @(negedge clk); #1;

        checkOutput("done_busy_exclusive", overlap, 0);

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule
